trojan1_counter1_host: RTL and testbench

//  Parametrised up/down counter host for Trojan1: configurable width, modulus,

---
 rtl/trojan1_counter_pkg.sv | 21 ++
 rtl/Trojan1.sv | 37 +++
 rtl/counter_lfsr.sv | 38 +++
 rtl/trojan1_counter1_host.sv | 173 +++++++++++++++++
 tb/tb_trojan1_counter1_host.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/trojan1_counter_pkg.sv
// ---------------------------------------------------------------------------
// trojan1_counter_pkg: shared FSM state type and LFSR defaults. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package trojan1_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    OVF   = 2'd2,
    UNF   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_LFSR_SEED = 32'h0000_FF42;
  localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h0000_8888;

endpackage

`default_nettype wire

// File: rtl/Trojan1.sv
// ---------------------------------------------------------------------------
// Trojan1: counts r1 events and raises trigger when the event count saturates
// its all-ones value. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module Trojan1 (
  input  logic clk,
  input  logic rst,
  input  logic r1,
  output logic trigger
);

  logic [15:0] hits_q;
  logic [15:0] hits_d;

  always_comb begin
    hits_d = hits_q;
    if (r1) begin
      hits_d = hits_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q <= 16'd0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign trigger = &hits_q;

endmodule

`default_nettype wire

// File: rtl/counter_lfsr.sv
// ---------------------------------------------------------------------------
// counter_lfsr: free-running Fibonacci LFSR, shifts left every cycle. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module counter_lfsr
  import trojan1_counter_pkg::*;
#(
  parameter int unsigned     W    = 16,
  parameter logic [W-1:0]    SEED = DEFAULT_LFSR_SEED[W-1:0],
  parameter logic [W-1:0]    TAPS = DEFAULT_LFSR_TAPS[W-1:0]
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] lfsr
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/trojan1_counter1_host.sv
// ---------------------------------------------------------------------------
// trojan1_counter1_host: up/down wrap/saturate counter with LFSR or external
// load source, hosting Trojan1. Optional macro: COUNTER_PRESCALE_EN. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module trojan1_counter1_host
  import trojan1_counter_pkg::*;
#(
  parameter int unsigned  COUNTER_WIDTH = 16,
  parameter int unsigned  MAX_COUNT     = (1 << COUNTER_WIDTH) - 1,
  parameter logic [31:0]  LFSR_SEED     = DEFAULT_LFSR_SEED,
  parameter logic [31:0]  LFSR_TAPS     = DEFAULT_LFSR_TAPS,
  parameter int unsigned  PRESCALE      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     count_enable,
  input  logic                     count_direction,
  input  logic                     load_enable,
  input  logic                     load_sel,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic                     sat_mode,
  output logic [COUNTER_WIDTH-1:0] counter_value,
  output logic                     counter_overflow,
  output logic                     counter_underflow
);

  localparam int unsigned W = COUNTER_WIDTH;
  localparam logic [W-1:0] MAX_C = MAX_COUNT[W-1:0];

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned C_PS = PRESCALE;
`else
  // Divisor pinned to 1: every COUNT cycle is a tick.
  localparam int unsigned C_PS = (PRESCALE >= 1) ? 1 : 1;
`endif
  localparam int unsigned C_PS_W = (C_PS > 1) ? $clog2(C_PS) : 1;
  localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(C_PS - 1);

  logic [W-1:0] lfsr;
  logic         r1;
  logic         trigger;

  state_e        state_q, state_d;
  logic [W-1:0]  counter_q, counter_d;
  logic [W-1:0]  cv_q, cv_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [C_PS_W-1:0] ps_q, ps_d;

  logic [W-1:0] load_raw;
  logic [W-1:0] load_data;
  logic         tick;

  counter_lfsr #(
    .W    (W),
    .SEED (LFSR_SEED[W-1:0]),
    .TAPS (LFSR_TAPS[W-1:0])
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign r1 = &lfsr[3:0];

  Trojan1 u_trojan (
    .clk     (clk),
    .rst     (~rst_n),
    .r1      (r1),
    .trigger (trigger)
  );

  // Extra MSB keeps the clamp compare meaningful when MAX_C is all ones.
  assign load_raw  = load_sel ? load_value : lfsr;
  assign load_data = ({1'b0, load_raw} > {1'b0, MAX_C}) ? MAX_C : load_raw;
  assign tick      = (ps_q == C_PS_LAST);

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ps_d      = ps_q;
    cv_d      = counter_q;
    if (trigger) begin
      state_d   = IDLE;
      counter_d = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      ps_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (load_enable) begin
            counter_d = load_data;
            ps_d      = '0;
          end else if (count_enable) begin
            state_d = COUNT;
            ps_d    = '0;
          end
        end
        COUNT: begin
          if (!count_enable) begin
            state_d = IDLE;
          end else if (load_enable) begin
            counter_d = load_data;
            ps_d      = '0;
          end else if (!tick) begin
            ps_d = ps_q + C_PS_W'(1);
          end else begin
            ps_d = '0;
            if (!count_direction) begin
              if (counter_q == MAX_C) begin
                ovf_d     = 1'b1;
                state_d   = OVF;
                counter_d = sat_mode ? MAX_C : '0;
              end else begin
                counter_d = counter_q + W'(1);
              end
            end else begin
              if (counter_q == '0) begin
                unf_d     = 1'b1;
                state_d   = UNF;
                counter_d = sat_mode ? '0 : MAX_C;
              end else begin
                counter_d = counter_q - W'(1);
              end
            end
          end
        end
        OVF: begin
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
        UNF: begin
          unf_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      cv_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ps_q      <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      cv_q      <= cv_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ps_q      <= ps_d;
    end
  end

  assign counter_value     = cv_q;
  assign counter_overflow  = ovf_q;
  assign counter_underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_trojan1_counter1_host.sv
// ---------------------------------------------------------------------------
// tb_trojan1_counter1_host: directed scoreboard bench, W=8, MAX_COUNT=9. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_trojan1_counter1_host;
  import trojan1_counter_pkg::*;

  localparam logic [7:0] SEED8 = 8'h42;
  localparam logic [7:0] TAPS8 = 8'h88;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce    = 1'b0;
  logic       dir   = 1'b0;
  logic       le    = 1'b0;
  logic       ls    = 1'b0;
  logic       sat   = 1'b0;
  logic [7:0] lv    = 8'd0;
  logic [7:0] cv;
  logic       ovf;
  logic       unf;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] cv;
    logic       ovf;
    logic       unf;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } imm_t;

  exp_t sb_q[$];
  imm_t imm_q[$];
  logic [7:0] m_lfsr;

  always #5 clk = ~clk;

  trojan1_counter1_host #(
    .COUNTER_WIDTH (8),
    .MAX_COUNT     (9),
    .PRESCALE      (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .count_enable      (ce),
    .count_direction   (dir),
    .load_enable       (le),
    .load_sel          (ls),
    .load_value        (lv),
    .sat_mode          (sat),
    .counter_value     (cv),
    .counter_overflow  (ovf),
    .counter_underflow (unf)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED8;
    else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & TAPS8)};
  end

  // Monitor: owns the counters, pops expectations every falling edge.
  initial begin
    exp_t e;
    imm_t m;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({cv, ovf, unf} !== e) begin
          errors++;
          $display("FAIL outputs@%0t: actual cv=%0d ovf=%b unf=%b, required cv=%0d ovf=%b unf=%b",
                   $time, cv, ovf, unf, e.cv, e.ovf, e.unf);
        end
      end
      while (imm_q.size() > 0) begin
        m = imm_q.pop_front();
        checks++;
        if (m.act !== m.exp) begin
          errors++;
          $display("FAIL %s@%0t: actual %0h, required %0h", m.name, $time, m.act, m.exp);
        end
      end
    end
  end

  task automatic step(input logic [7:0] c, input logic o, input logic u);
    exp_t e;
    @(posedge clk);
    #1;
    e.cv = c; e.ovf = o; e.unf = u;
    sb_q.push_back(e);
  endtask

  task automatic snap(input string n, input logic [31:0] a, input logic [31:0] x);
    imm_t t;
    t.name = n; t.act = a; t.exp = x;
    imm_q.push_back(t);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0);
    snap("reset_lfsr", 32'(dut.lfsr), 32'(SEED8));
    ce = 1'b1; dir = 1'b0; sat = 1'b0;
    rst_n = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    step(8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(8'd1, 1'b0, 1'b0);
    step(8'd2, 1'b0, 1'b0);
    ls = 1'b1; lv = 8'd5; le = 1'b1;
    step(8'd2, 1'b0, 1'b0);
    le = 1'b0;
    for (int k = 0; k < 4; k++) step(8'd5, 1'b0, 1'b0);
    step(8'd6, 1'b0, 1'b0);
`else
    // Up count with wrap
    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0);
    for (int k = 3; k <= 11; k++) step(8'(k - 2), (k == 11), 1'b0);
    step(8'd0, 1'b0, 1'b0);
    ce = 1'b0;
    step(8'd0, 1'b0, 1'b0);
    snap("lfsr_run", 32'(dut.lfsr), 32'(m_lfsr));

    // External load 3, down count with saturate
    ls = 1'b1; lv = 8'd3; le = 1'b1; dir = 1'b1; sat = 1'b1; ce = 1'b1;
    step(8'd0, 1'b0, 1'b0);
    le = 1'b0;
    step(8'd3, 1'b0, 1'b0);
    step(8'd3, 1'b0, 1'b0);
    step(8'd2, 1'b0, 1'b0);
    step(8'd1, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b1);
    ce = 1'b0;
    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0);

    // Load clamp
    lv = 8'd200; le = 1'b1;
    step(8'd0, 1'b0, 1'b0);
    le = 1'b0;
    step(8'd9, 1'b0, 1'b0);

    // Saturate at top
    lv = 8'd9; le = 1'b1; sat = 1'b1; dir = 1'b0; ce = 1'b1;
    step(8'd9, 1'b0, 1'b0);
    le = 1'b0;
    step(8'd9, 1'b0, 1'b0);
    step(8'd9, 1'b1, 1'b0);
    step(8'd9, 1'b0, 1'b0);

    // Wrap below zero
    lv = 8'd0; le = 1'b1; dir = 1'b1; sat = 1'b0;
    step(8'd9, 1'b0, 1'b0);
    le = 1'b0;
    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b1);
    ce = 1'b0;
    step(8'd9, 1'b0, 1'b0);
    step(8'd9, 1'b0, 1'b0);

    // Trigger at counter=5
    lv = 8'd0; le = 1'b1;
    step(8'd9, 1'b0, 1'b0);
    le = 1'b0; ce = 1'b1; dir = 1'b0;
    step(8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(8'(k), 1'b0, 1'b0);
    force dut.trigger = 1'b1;
    step(8'd5, 1'b0, 1'b0);
    release dut.trigger;
    snap("trig_state", 32'(dut.state_q), 32'(IDLE));
    snap("trig_lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    step(8'd0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0);
    ce = 1'b0;
    step(8'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-count
    ce = 1'b1;
    step(8'd1, 1'b0, 1'b0);
    step(8'd1, 1'b0, 1'b0);
    step(8'd2, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    snap("async_cv", 32'(cv), 32'd0);
    snap("async_flags", 32'({ovf, unf}), 32'd0);
    snap("async_lfsr", 32'(dut.lfsr), 32'(SEED8));
    #1 rst_n = 1'b1;
    ce = 1'b0;
    #1;
    snap("release_lfsr", 32'(dut.lfsr), 32'(SEED8));
    step(8'd0, 1'b0, 1'b0);
    snap("post_lfsr", 32'(dut.lfsr), 32'(m_lfsr));
`endif

    for (int k = 0; k < 10 && (sb_q.size() > 0 || imm_q.size() > 0); k++) begin
      @(negedge clk);
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
